// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MEM-stage data-memory controller with halfword and two-beat word access
//
// Owns a DATAWIDTH-wide data array and serves halfword (one array entry) and
// word (two consecutive entries, little-endian) loads and stores for the
// pipeline. Word accesses take a second beat in the HIGH state and raise a
// one-cycle combinational stall so the pipeline holds the instruction.
// Stores are suppressed for dirty or skipped instructions; loads are not.
//
// Optional feature macro: MEM_CTRL_ALIGN_CHECK_EN
//   defined   : misaligned accesses fault (no write, no state change,
//               done and misalign pulse on the next cycle)
//   undefined : low address bits below OFF are ignored, misalign stays 0
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset, highest priority
//   req       access valid this cycle
//   dirty     instruction dirty, store suppressed
//   skip      instruction skipped, store suppressed
//   wr        1 = store, 0 = load
//   size      0 = halfword, 1 = word
//   addr      byte address, index = addr[ADDRWIDTH+OFF-1:OFF]
//   wdata     store data, halfword uses the low DATAWIDTH bits
//   rdata     registered load result
//   done      one-cycle completion pulse
//   stall     combinational hold request for the low beat of a word
//   misalign  registered alignment fault flag

module mem_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   dirty,
  input  logic                   skip,
  input  logic                   wr,
  input  logic                   size,
  input  logic [31:0]            addr,
  input  logic [2*DATAWIDTH-1:0] wdata,
  output logic [2*DATAWIDTH-1:0] rdata,
  output logic                   done,
  output logic                   stall,
  output logic                   misalign
);

  localparam int BYTES = DATAWIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int DEPTH = 2 ** ADDRWIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDRWIDTH-1:0] index;
  logic [ADDRWIDTH-1:0] rd_idx;
  logic [ADDRWIDTH-1:0] mem_idx;
  logic [ADDRWIDTH-1:0] hi_idx;
  logic [DATAWIDTH-1:0] hi_wdata;
  logic [DATAWIDTH-1:0] lo_rdata;
  logic [DATAWIDTH-1:0] rd_data;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 hi_we;
  logic                 hi_load;
  logic                 fault;
  logic                 we;
  logic                 mem_we;
  logic                 mis_q;
  logic                 unused_addr;

  assign index       = addr[ADDRWIDTH+OFF-1:OFF];
  assign unused_addr = ^addr;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam logic [31:0] HW_MASK = (32'd1 << OFF) - 32'd1;
  localparam logic [31:0] WD_MASK = (32'd1 << (OFF + 1)) - 32'd1;
  assign fault = req && ((addr & (size ? WD_MASK : HW_MASK)) != 32'd0);
`else
  assign fault = 1'b0;
`endif

  assign we    = req && wr && !dirty && !skip && !fault;
  assign stall = (state == IDLE) && req && size && !fault;

  // In HIGH the held pipeline inputs are ignored; only latched values are used.
  assign rd_idx  = (state == HIGH) ? hi_idx : index;
  assign rd_data = mem[rd_idx];

  // Write port gated by rst so a reset landing in HIGH drops the high beat.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = index;
    mem_wdata = wdata[DATAWIDTH-1:0];
    if (!rst) begin
      if (state == IDLE) begin
        mem_we = we;
      end else begin
        mem_we    = hi_we;
        mem_idx   = hi_idx;
        mem_wdata = hi_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdata    <= '0;
      done     <= 1'b0;
      mis_q    <= 1'b0;
      hi_idx   <= '0;
      hi_wdata <= '0;
      hi_we    <= 1'b0;
      hi_load  <= 1'b0;
      lo_rdata <= '0;
    end else begin
      done  <= 1'b0;
      mis_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              done  <= 1'b1;
              mis_q <= 1'b1;
            end else if (!size) begin
              if (!wr) rdata <= {{DATAWIDTH{1'b0}}, rd_data};
              done <= 1'b1;
            end else begin
              // Index wraps naturally at ADDRWIDTH bits.
              hi_idx   <= index + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
              hi_wdata <= wdata[2*DATAWIDTH-1:DATAWIDTH];
              hi_we    <= we;
              hi_load  <= !wr;
              // Low half is parked so rdata only changes when the word completes.
              lo_rdata <= rd_data;
              state    <= HIGH;
            end
          end
        end
        HIGH: begin
          if (hi_load) rdata <= {rd_data, lo_rdata};
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Without alignment checking fault is constant 0, so mis_q never sets.
  assign misalign = mis_q;

endmodule
